// File: rtl/frac_div_pkg.sv
// Shared types and constants for the fractional clock-divider controller.
// Holds default field widths, the FSM encoding and the config legality check.
package frac_div_pkg;

    localparam int          INT_W_DEF  = 8;
    localparam int          FRAC_W_DEF = 8;
    localparam int unsigned MIN_INT    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    typedef struct packed {
        logic [INT_W_DEF-1:0]  ipart;
        logic [FRAC_W_DEF-1:0] num;
        logic [FRAC_W_DEF-1:0] den;
    } cfg_t;

    function automatic logic cfg_legal(input int unsigned ci, input int unsigned cn, input int unsigned cd);
        return (ci >= MIN_INT) && (cd != 0) && (cn < cd);
    endfunction

endpackage

// File: rtl/frac_div_ctrl_if.sv
// Config handshake plus divided-clock status bundle between the register block and the divider.
interface frac_div_ctrl_if #(
    parameter int INT_W  = frac_div_pkg::INT_W_DEF,
    parameter int FRAC_W = frac_div_pkg::FRAC_W_DEF
);
    logic              enable;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [INT_W-1:0]  cfg_int;
    logic [FRAC_W-1:0] cfg_num;
    logic [FRAC_W-1:0] cfg_den;
    logic              clk_out;
    logic              seq_done;
    logic              busy;
    logic              cfg_pend;
    logic              cfg_err;

    modport master (
        output enable, cfg_valid, cfg_int, cfg_num, cfg_den,
        input  cfg_ready, clk_out, seq_done, busy, cfg_pend, cfg_err
    );

    modport slave (
        input  enable, cfg_valid, cfg_int, cfg_num, cfg_den,
        output cfg_ready, clk_out, seq_done, busy, cfg_pend, cfg_err
    );
endinterface

// File: rtl/frac_div_core.sv
// Period counter, error accumulator and period index of the fractional divider.
// Latency: pulse/boundary decoded from registers in the last cycle of each period.
// Backpressure: none; counts every cycle while run is high, restart zeroes all state.
module frac_div_core
    import frac_div_pkg::*;
#(
    parameter int INT_W  = INT_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              run,
    input  logic              restart,
    input  logic [INT_W-1:0]  len_int,
    input  logic [FRAC_W-1:0] num,
    input  logic [FRAC_W-1:0] den,
    output logic              pulse,
    output logic              boundary
);
    logic [INT_W-1:0]  cnt;
    logic [INT_W-1:0]  last_cnt;
    logic [FRAC_W:0]   acc;
    logic [FRAC_W:0]   acc_sum;
    logic [FRAC_W-1:0] idx;
    logic              long_q;

    assign acc_sum  = acc + {1'b0, num};
    // len_int >= 2, so cnt==0 is never the last cycle and long_q is always settled here
    assign last_cnt = len_int - INT_W'(1) + INT_W'(long_q);
    assign pulse    = run && (cnt == last_cnt);
    assign boundary = pulse && (idx == den - FRAC_W'(1));

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            acc    <= '0;
            idx    <= '0;
            long_q <= 1'b0;
        end else if (restart) begin
            cnt    <= '0;
            acc    <= '0;
            idx    <= '0;
            long_q <= 1'b0;
        end else if (run) begin
            if (cnt == '0) begin
                if (acc_sum >= {1'b0, den}) begin
                    long_q <= 1'b1;
                    acc    <= acc_sum - {1'b0, den};
                end else begin
                    long_q <= 1'b0;
                    acc    <= acc_sum;
                end
            end
            if (pulse) begin
                cnt <= '0;
                idx <= boundary ? '0 : idx + FRAC_W'(1);
            end else begin
                cnt <= cnt + INT_W'(1);
            end
        end
    end
endmodule

// File: rtl/frac_div_ctrl.sv
// Fractional clock-divider controller: run/stop FSM, config handshake, shadow config.
// Latency: idle config is active next cycle; running retunes land at the next sequence boundary.
// Backpressure: cfg_ready is low while a shadow config waits for a boundary.
module frac_div_ctrl
    import frac_div_pkg::*;
#(
    parameter int INT_W  = INT_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input logic            clk_in,
    input logic            rst,
    frac_div_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_STOP = STOP;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [INT_W-1:0]  act_int, shd_int;
    logic [FRAC_W-1:0] act_num, act_den, shd_num, shd_den;
    logic              loaded, pend, err_q;
    logic              xfer, legal, swap, pulse, boundary;

    assign xfer  = bus.cfg_valid && !pend;
    assign legal = cfg_legal(32'(bus.cfg_int), 32'(bus.cfg_num), 32'(bus.cfg_den));
    // a shadow left over when the run ended is promoted as soon as we are idle
    assign swap  = pend && (boundary || (state == S_IDLE));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (bus.enable && loaded) state_nx = S_RUN;
            S_RUN: begin
                if (boundary)         state_nx = bus.enable ? S_RUN : S_IDLE;
                else if (!bus.enable) state_nx = S_STOP;
            end
            S_STOP: begin
                if (boundary)        state_nx = bus.enable ? S_RUN : S_IDLE;
                else if (bus.enable) state_nx = S_RUN;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            act_int <= '0;
            act_num <= '0;
            act_den <= '0;
            shd_int <= '0;
            shd_num <= '0;
            shd_den <= '0;
            loaded  <= 1'b0;
            pend    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= xfer && !legal;
            if (swap) begin
                act_int <= shd_int;
                act_num <= shd_num;
                act_den <= shd_den;
                pend    <= 1'b0;
            end
            if (xfer && legal) begin
                if (state == S_IDLE) begin
                    act_int <= bus.cfg_int;
                    act_num <= bus.cfg_num;
                    act_den <= bus.cfg_den;
                    loaded  <= 1'b1;
                end else begin
                    shd_int <= bus.cfg_int;
                    shd_num <= bus.cfg_num;
                    shd_den <= bus.cfg_den;
                    pend    <= 1'b1;
                end
            end
        end
    end

    frac_div_core #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) u_core (
        .clk_in   (clk_in),
        .rst      (rst),
        .run      (state != S_IDLE),
        .restart  ((state == S_IDLE) || swap),
        .len_int  (act_int),
        .num      (act_num),
        .den      (act_den),
        .pulse    (pulse),
        .boundary (boundary)
    );

    assign bus.cfg_ready = !pend;
    assign bus.clk_out   = pulse;
    assign bus.seq_done  = boundary;
    assign bus.busy      = (state != S_IDLE);
    assign bus.cfg_pend  = pend;
    assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_frac_div_ctrl.sv
// Self-checking bench for frac_div_ctrl: table of ratios with expected period patterns,
// plus hand sequences for retune, early stop and mid-run reset.
module tb_frac_div_ctrl;
    import frac_div_pkg::*;

    localparam int BUDGET = 4000;
    localparam int NV     = 10;

    typedef struct {
        cfg_t             c;
        bit               err;
        int               nlen;
        logic [0:9][8:0]  lens;
    } vec_t;

    typedef struct {
        int len;
        bit sd;
    } exp_t;

    logic   clk_in = 1'b0;
    logic   rst    = 1'b0;
    vec_t   tbl [NV];
    exp_t   sb [$];
    int     n_tests = 0;
    int     n_fail  = 0;

    frac_div_ctrl_if #(.INT_W(8), .FRAC_W(8)) bus ();

    frac_div_ctrl #(.INT_W(8), .FRAC_W(8)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every clk_out must match the next queued period.
    initial begin : mon
        int   plen;
        exp_t e;
        plen = 0;
        forever begin
            @(negedge clk_in);
            if (!bus.busy) plen = 0;
            else           plen++;
            if (bus.clk_out) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("period_len", plen, e.len);
                    check("seq_done", int'(bus.seq_done), int'(e.sd));
                end
                plen = 0;
            end
        end
    end

    task automatic push_seq(input int v, input int reps);
        exp_t e;
        for (int r = 0; r < reps; r++) begin
            for (int k = 0; k < tbl[v].nlen; k++) begin
                e.len = int'(tbl[v].lens[k]);
                e.sd  = (k == tbl[v].nlen - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        bus.enable    = 1'b0;
        bus.cfg_valid = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk_in);
        check("rst_cfg_ready", int'(bus.cfg_ready), 1);
        check("rst_clk_out", int'(bus.clk_out), 0);
        check("rst_seq_done", int'(bus.seq_done), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_cfg_pend", int'(bus.cfg_pend), 0);
        check("rst_cfg_err", int'(bus.cfg_err), 0);
        rst = 1'b1;
        @(negedge clk_in);
    endtask

    // Returns at the negedge right after the transfer edge.
    task automatic send_cfg(input logic [7:0] ci, input logic [7:0] cn, input logic [7:0] cd);
        int t;
        t = 0;
        @(negedge clk_in);
        bus.cfg_valid = 1'b1;
        bus.cfg_int   = ci;
        bus.cfg_num   = cn;
        bus.cfg_den   = cd;
        while (!bus.cfg_ready && t < BUDGET) begin
            @(negedge clk_in);
            t++;
        end
        check("cfg_ready_wait", int'(bus.cfg_ready), 1);
        @(negedge clk_in);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_sb(input int n);
        int t;
        t = 0;
        while (sb.size() > n && t < BUDGET) begin
            @(negedge clk_in);
            t++;
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((sb.size() != 0 || bus.busy) && t < BUDGET) begin
            @(negedge clk_in);
            t++;
        end
        check({tag, "_sb_left"}, sb.size(), 0);
        check({tag, "_busy_end"}, int'(bus.busy), 0);
        repeat (30) @(negedge clk_in);
        check({tag, "_idle_quiet"}, int'(bus.busy), 0);
    endtask

    initial begin
        int t;
        bus.enable    = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_int   = '0;
        bus.cfg_num   = '0;
        bus.cfg_den   = '0;

        tbl[0] = '{'{8'd8,   8'd7, 8'd10}, 1'b0, 10, {9'd8, 9'd9, 9'd9, 9'd8, 9'd9, 9'd9, 9'd8, 9'd9, 9'd9, 9'd9}};
        tbl[1] = '{'{8'd4,   8'd1, 8'd3},  1'b0, 3,  {9'd4, 9'd4, 9'd5, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0}};
        tbl[2] = '{'{8'd5,   8'd0, 8'd1},  1'b0, 1,  {9'd5, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0}};
        tbl[3] = '{'{8'd2,   8'd1, 8'd2},  1'b0, 2,  {9'd2, 9'd3, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0}};
        tbl[4] = '{'{8'd3,   8'd2, 8'd3},  1'b0, 3,  {9'd3, 9'd4, 9'd4, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0}};
        tbl[5] = '{'{8'd255, 8'd1, 8'd2},  1'b0, 2,  {9'd255, 9'd256, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0}};
        tbl[6] = '{'{8'd3,   8'd0, 8'd4},  1'b0, 4,  {9'd3, 9'd3, 9'd3, 9'd3, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0}};
        tbl[7] = '{'{8'd1,   8'd0, 8'd1},  1'b1, 0,  '0};
        tbl[8] = '{'{8'd5,   8'd0, 8'd0},  1'b1, 0,  '0};
        tbl[9] = '{'{8'd6,   8'd3, 8'd3},  1'b1, 0,  '0};

        for (int v = 0; v < NV; v++) begin
            do_reset();
            send_cfg(tbl[v].c.ipart, tbl[v].c.num, tbl[v].c.den);
            if (tbl[v].err) begin
                check("err_pulse", int'(bus.cfg_err), 1);
                check("err_pend", int'(bus.cfg_pend), 0);
                @(negedge clk_in);
                check("err_once", int'(bus.cfg_err), 0);
                bus.enable = 1'b1;
                repeat (20) @(negedge clk_in);
                check("err_no_run", int'(bus.busy), 0);
                bus.enable = 1'b0;
            end else begin
                check("load_err_quiet", int'(bus.cfg_err), 0);
                check("load_pend_idle", int'(bus.cfg_pend), 0);
                check("load_busy", int'(bus.busy), 0);
                push_seq(v, 2);
                bus.enable = 1'b1;
                wait_sb(tbl[v].nlen);
                repeat (2) @(negedge clk_in);
                bus.enable = 1'b0;
                drain("vec");
            end
        end

        // Retune mid-sequence; an illegal offer in between must leave the running ratio alone.
        do_reset();
        send_cfg(8'd8, 8'd7, 8'd10);
        push_seq(0, 1);
        bus.enable = 1'b1;
        wait_sb(7);
        send_cfg(8'd3, 8'd5, 8'd4);
        check("run_illegal_err", int'(bus.cfg_err), 1);
        check("run_illegal_pend", int'(bus.cfg_pend), 0);
        send_cfg(8'd4, 8'd1, 8'd3);
        check("retune_pend", int'(bus.cfg_pend), 1);
        check("retune_ready_low", int'(bus.cfg_ready), 0);
        push_seq(1, 2);
        t = 0;
        while (!bus.seq_done && t < BUDGET) begin
            @(negedge clk_in);
            t++;
        end
        check("retune_pend_at_boundary", int'(bus.cfg_pend), 1);
        @(negedge clk_in);
        check("retune_pend_clear", int'(bus.cfg_pend), 0);
        check("retune_ready_back", int'(bus.cfg_ready), 1);
        wait_sb(3);
        repeat (2) @(negedge clk_in);
        bus.enable = 1'b0;
        drain("retune");

        // Drop enable from period 2: the sequence still runs to idx 9, then stops.
        do_reset();
        send_cfg(8'd8, 8'd7, 8'd10);
        push_seq(0, 1);
        bus.enable = 1'b1;
        wait_sb(8);
        bus.enable = 1'b0;
        @(negedge clk_in);
        check("stop_busy_held", int'(bus.busy), 1);
        drain("stop");

        // Asynchronous reset mid-period, then enable alone must not start anything.
        do_reset();
        send_cfg(8'd8, 8'd7, 8'd10);
        push_seq(0, 1);
        bus.enable = 1'b1;
        wait_sb(8);
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        #1;
        check("arst_clk_out", int'(bus.clk_out), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_ready", int'(bus.cfg_ready), 1);
        sb.delete();
        @(negedge clk_in);
        rst = 1'b1;
        repeat (40) @(negedge clk_in);
        check("arst_no_config", int'(bus.busy), 0);
        push_seq(2, 2);
        send_cfg(8'd5, 8'd0, 8'd1);
        wait_sb(1);
        repeat (2) @(negedge clk_in);
        bus.enable = 1'b0;
        drain("arst_reload");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
